// File: rtl/legv8_control_unit_pkg.sv
// Shared definitions for the LEGv8 control unit: opcodes, ALU function codes,
// sequencer states and the datapath control word.
package legv8_ctrl_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;

  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  localparam logic [9:0]  OP_EORI = 10'b1101001000;

  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [4:0]  FS_AND  = 5'b00000;
  localparam logic [4:0]  FS_ORR  = 5'b00100;
  localparam logic [4:0]  FS_ADD  = 5'b01000;
  localparam logic [4:0]  FS_EOR  = 5'b01100;
  localparam logic [4:0]  FS_SUB  = 5'b01001;

  localparam logic [1:0]  RAM_SIZE_64 = 2'b11;
  localparam logic [4:0]  REG_XZR     = 5'd31;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM2  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] k;
    logic        b_sel;
    logic        en_alu;
    logic        en_b;
    logic        en_addr_alu;
    logic        w_reg;
    logic        ram_cs;
    logic        ram_write_en;
    logic        ram_read_en;
  } ctrl_word_t;

  // Subtraction is the only function that needs the two's-complement carry-in.
  function automatic logic fs_carry_in(input logic [4:0] fs);
    return (fs == FS_SUB);
  endfunction

endpackage

// File: rtl/legv8_control_unit_if.sv
// Fetch and control-word bus between the control unit (master) and the
// instruction ROM / datapath (slave).
interface legv8_control_unit_if;
  logic [63:0] instr_addr;
  logic [31:0] instr_data;
  logic [3:0]  status;
  logic [4:0]  SA;
  logic [4:0]  SB;
  logic [4:0]  DA;
  logic [4:0]  FS;
  logic        C0;
  logic [63:0] k;
  logic        B_Sel;
  logic        EN_ALU;
  logic        EN_B;
  logic        EN_ADDR_ALU;
  logic        w_reg;
  logic        ram_cs;
  logic        ram_write_en;
  logic        ram_read_en;
  logic [1:0]  ramOutsize;
  logic [63:0] pc;
  logic        halted;

  modport master (
    output instr_addr, SA, SB, DA, FS, C0, k, B_Sel, EN_ALU, EN_B, EN_ADDR_ALU,
           w_reg, ram_cs, ram_write_en, ram_read_en, ramOutsize, pc, halted,
    input  instr_data, status
  );

  modport slave (
    input  instr_addr, SA, SB, DA, FS, C0, k, B_Sel, EN_ALU, EN_B, EN_ADDR_ALU,
           w_reg, ram_cs, ram_write_en, ram_read_en, ramOutsize, pc, halted,
    output instr_data, status
  );
endinterface

// File: rtl/legv8_control_unit_decoder.sv
// Combinational instruction decoder: IR plus sequencer state to the datapath
// control word and the instruction class flags the sequencer needs.
module legv8_decoder
  import legv8_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  input  state_t      state,
  output ctrl_word_t  cw,
  output logic        is_alu,
  output logic        is_load,
  output logic        is_store,
  output logic        is_cb,
  output logic        is_b,
  output logic        illegal
);

  logic        is_imm_s;
  logic [4:0]  alu_fs_s;
  logic [63:0] imm12_s;
  logic [63:0] addr9_s;

  assign imm12_s = {52'd0, ir[21:10]};
  assign addr9_s = {{55{ir[20]}}, ir[20:12]};

  // Address-generation word shared by LDUR (both cycles) and STUR.
  function automatic ctrl_word_t mem_addr_word(input logic [31:0] w, input logic [63:0] off);
    ctrl_word_t c;
    c             = '0;
    c.sa          = w[9:5];
    c.sb          = w[4:0];
    c.k           = off;
    c.b_sel       = 1'b1;
    c.fs          = FS_ADD;
    c.en_addr_alu = 1'b1;
    c.ram_cs      = 1'b1;
    return c;
  endfunction

  // Opcode classification, priority from the 11-bit field down to the 6-bit field.
  always_comb begin
    is_alu   = 1'b0;
    is_imm_s = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_cb    = 1'b0;
    is_b     = 1'b0;
    illegal  = 1'b0;
    alu_fs_s = FS_AND;
    if (ir[31:21] == OP_ADD) begin
      is_alu = 1'b1; alu_fs_s = FS_ADD;
    end else if (ir[31:21] == OP_SUB) begin
      is_alu = 1'b1; alu_fs_s = FS_SUB;
    end else if (ir[31:21] == OP_AND) begin
      is_alu = 1'b1; alu_fs_s = FS_AND;
    end else if (ir[31:21] == OP_ORR) begin
      is_alu = 1'b1; alu_fs_s = FS_ORR;
    end else if (ir[31:21] == OP_EOR) begin
      is_alu = 1'b1; alu_fs_s = FS_EOR;
    end else if (ir[31:21] == OP_STUR) begin
      is_store = 1'b1;
    end else if (ir[31:21] == OP_LDUR) begin
      is_load = 1'b1;
    end else if (ir[31:22] == OP_ADDI) begin
      is_alu = 1'b1; is_imm_s = 1'b1; alu_fs_s = FS_ADD;
    end else if (ir[31:22] == OP_SUBI) begin
      is_alu = 1'b1; is_imm_s = 1'b1; alu_fs_s = FS_SUB;
    end else if (ir[31:22] == OP_ANDI) begin
      is_alu = 1'b1; is_imm_s = 1'b1; alu_fs_s = FS_AND;
    end else if (ir[31:22] == OP_ORRI) begin
      is_alu = 1'b1; is_imm_s = 1'b1; alu_fs_s = FS_ORR;
    end else if (ir[31:22] == OP_EORI) begin
      is_alu = 1'b1; is_imm_s = 1'b1; alu_fs_s = FS_EOR;
    end else if ((ir[31:24] == OP_CBZ) || (ir[31:24] == OP_CBNZ)) begin
      is_cb = 1'b1;
    end else if (ir[31:26] == OP_B) begin
      is_b = 1'b1;
    end else begin
      illegal = 1'b1;
    end
  end

  // Control word per state; FETCH, HALT and B leave every enable low.
  always_comb begin
    cw = '0;
    case (state)
      ST_EXEC: begin
        if (is_alu) begin
          cw.sa     = ir[9:5];
          cw.sb     = ir[20:16];
          cw.da     = ir[4:0];
          cw.fs     = alu_fs_s;
          cw.c0     = fs_carry_in(alu_fs_s);
          cw.b_sel  = is_imm_s;
          cw.k      = is_imm_s ? imm12_s : 64'd0;
          cw.en_alu = 1'b1;
          cw.w_reg  = 1'b1;
        end else if (is_store) begin
          cw              = mem_addr_word(ir, addr9_s);
          cw.en_b         = 1'b1;
          cw.ram_write_en = 1'b1;
        end else if (is_load) begin
          cw             = mem_addr_word(ir, addr9_s);
          cw.ram_read_en = 1'b1;
        end else if (is_cb) begin
          // Rt OR 0 through the ALU so Z reflects Rt == 0.
          cw.sa    = ir[4:0];
          cw.k     = 64'd0;
          cw.b_sel = 1'b1;
          cw.fs    = FS_ORR;
        end else begin
          cw = '0;
        end
      end
      ST_MEM2: begin
        cw             = mem_addr_word(ir, addr9_s);
        cw.ram_read_en = 1'b1;
        cw.da          = ir[4:0];
        cw.w_reg       = 1'b1;
      end
      default: begin
        cw = '0;
      end
    endcase
    if (cw.da == REG_XZR) begin
      cw.w_reg = 1'b0;
    end else begin
      cw.w_reg = cw.w_reg;
    end
  end

endmodule

// File: rtl/legv8_control_unit.sv
// LEGv8 multi-cycle sequencer: PC, instruction register, branch adder and the
// FETCH/EXEC/MEM2/HALT state machine driving the datapath control word.
module legv8_control_unit
  import legv8_ctrl_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input logic                  clock,
  input logic                  reset,
  legv8_control_unit_if.master bus
);

  state_t      state_r;
  state_t      next_state_s;
  logic [63:0] pc_r;
  logic [63:0] pc_next_s;
  logic [63:0] ipc_r;
  logic [31:0] ir_r;
  ctrl_word_t  cw_s;
  ctrl_word_t  cw_out_s;
  logic        is_alu_s;
  logic        is_load_s;
  logic        is_store_s;
  logic        is_cb_s;
  logic        is_b_s;
  logic        illegal_s;
  logic        known_op_s;
  logic        z_flag_s;
  logic        cb_taken_s;
  logic [63:0] cb_target_s;
  logic [63:0] b_target_s;

  legv8_decoder u_decoder (
    .ir       (ir_r),
    .state    (state_r),
    .cw       (cw_s),
    .is_alu   (is_alu_s),
    .is_load  (is_load_s),
    .is_store (is_store_s),
    .is_cb    (is_cb_s),
    .is_b     (is_b_s),
    .illegal  (illegal_s)
  );

  assign known_op_s  = is_alu_s | is_load_s | is_store_s | is_cb_s | is_b_s;
  assign z_flag_s    = bus.status[0];
  assign cb_taken_s  = ir_r[24] ? ~z_flag_s : z_flag_s;
  assign cb_target_s = ipc_r + {{43{ir_r[23]}}, ir_r[23:5], 2'b00};
  assign b_target_s  = ipc_r + {{36{ir_r[25]}}, ir_r[25:0], 2'b00};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // PC, instruction register and the PC of the instruction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r  <= PC_RESET;
      ir_r  <= 32'd0;
      ipc_r <= 64'd0;
    end else begin
      pc_r <= pc_next_s;
      if (state_r == ST_FETCH) begin
        ir_r  <= bus.instr_data;
        ipc_r <= pc_r;
      end else begin
        ir_r  <= ir_r;
        ipc_r <= ipc_r;
      end
    end
  end

  // Next-state logic; an unrecognised opcode parks the unit in HALT.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_FETCH: next_state_s = ST_EXEC;
      ST_EXEC: begin
        if (illegal_s || !known_op_s) begin
          next_state_s = ST_HALT;
        end else if (is_load_s) begin
          next_state_s = ST_MEM2;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_MEM2: next_state_s = ST_FETCH;
      ST_HALT: next_state_s = ST_HALT;
      default: next_state_s = ST_FETCH;
    endcase
  end

  // Next PC: sequential increment in FETCH, branch redirect relative to ipc in EXEC.
  always_comb begin
    pc_next_s = pc_r;
    case (state_r)
      ST_FETCH: pc_next_s = pc_r + 64'd4;
      ST_EXEC: begin
        if (is_b_s) begin
          pc_next_s = b_target_s;
        end else if (is_cb_s && cb_taken_s) begin
          pc_next_s = cb_target_s;
        end else begin
          pc_next_s = pc_r;
        end
      end
      default: pc_next_s = pc_r;
    endcase
  end

  // Output word; reset suppresses every strobe so an interrupted LDUR cannot write.
  always_comb begin
    if (reset) begin
      cw_out_s = '0;
    end else begin
      cw_out_s = cw_s;
    end
  end

  assign bus.instr_addr   = pc_r;
  assign bus.pc           = pc_r;
  assign bus.halted       = (state_r == ST_HALT);
  assign bus.ramOutsize   = RAM_SIZE_64;
  assign bus.SA           = cw_out_s.sa;
  assign bus.SB           = cw_out_s.sb;
  assign bus.DA           = cw_out_s.da;
  assign bus.FS           = cw_out_s.fs;
  assign bus.C0           = cw_out_s.c0;
  assign bus.k            = cw_out_s.k;
  assign bus.B_Sel        = cw_out_s.b_sel;
  assign bus.EN_ALU       = cw_out_s.en_alu;
  assign bus.EN_B         = cw_out_s.en_b;
  assign bus.EN_ADDR_ALU  = cw_out_s.en_addr_alu;
  assign bus.w_reg        = cw_out_s.w_reg;
  assign bus.ram_cs       = cw_out_s.ram_cs;
  assign bus.ram_write_en = cw_out_s.ram_write_en;
  assign bus.ram_read_en  = cw_out_s.ram_read_en;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Scoreboard bench: each cycle's expected control word is queued by the driver
// and compared by an independent negedge monitor.
module tb_legv8_control_unit;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] iaddr;
    logic [1:0]  osz;
    logic [4:0]  sa;
    logic [4:0]  sb;
    logic [4:0]  da;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] k;
    logic        b_sel;
    logic [7:0]  flags; // {en_alu, en_b, en_addr_alu, w_reg, ram_cs, ram_we, ram_re, halted}
  } obs_t;

  localparam logic [7:0] NONE   = 8'b0000_0000;
  localparam logic [7:0] ALU_W  = 8'b1001_0000;
  localparam logic [7:0] ALU_NW = 8'b1000_0000;
  localparam logic [7:0] LD_EX  = 8'b0010_1010;
  localparam logic [7:0] LD_M2  = 8'b0011_1010;
  localparam logic [7:0] ST_EX  = 8'b0110_1100;
  localparam logic [7:0] HLT    = 8'b0000_0001;
  localparam logic [63:0] K_M8  = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom [0:31];
  obs_t        exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          fails  = 0;

  legv8_control_unit_if bus ();

  legv8_control_unit #(.PC_RESET(64'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign bus.instr_data = (bus.instr_addr < 64'd128) ? rom[bus.instr_addr[6:2]] : 32'h0000_0000;

  function automatic obs_t mk(input logic [63:0] pc, input logic [4:0] sa, input logic [4:0] sb,
                              input logic [4:0] da, input logic [4:0] fs, input logic c0,
                              input logic [63:0] k, input logic b_sel, input logic [7:0] flags);
    obs_t o;
    o.pc = pc; o.iaddr = pc; o.osz = 2'b11;
    o.sa = sa; o.sb = sb; o.da = da; o.fs = fs; o.c0 = c0;
    o.k = k; o.b_sel = b_sel; o.flags = flags;
    return o;
  endfunction

  function automatic obs_t idle(input logic [63:0] pc, input logic halted);
    return mk(pc, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b0, {7'd0, halted});
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc = bus.pc; o.iaddr = bus.instr_addr; o.osz = bus.ramOutsize;
    o.sa = bus.SA; o.sb = bus.SB; o.da = bus.DA; o.fs = bus.FS; o.c0 = bus.C0;
    o.k = bus.k; o.b_sel = bus.B_Sel;
    o.flags = {bus.EN_ALU, bus.EN_B, bus.EN_ADDR_ALU, bus.w_reg,
               bus.ram_cs, bus.ram_write_en, bus.ram_read_en, bus.halted};
    return o;
  endfunction

  // One cycle: drive reset/Z after the edge and queue what that cycle must show.
  task automatic row(input string name, input logic r, input logic z, input obs_t e);
    @(posedge clock);
    #1;
    reset = r;
    bus.status = {3'b000, z};
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Monitor: pops one expectation per cycle, compared away from the rising edge.
  always @(negedge clock) begin
    obs_t  e;
    obs_t  a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = sample();
      checks = checks + 1;
      if (a !== e) begin
        fails = fails + 1;
        $display("FAIL %s: got pc=%h sa=%0d sb=%0d da=%0d fs=%b c0=%b k=%h bsel=%b flags=%b osz=%b | want pc=%h sa=%0d sb=%0d da=%0d fs=%b c0=%b k=%h bsel=%b flags=%b osz=%b",
                 n, a.pc, a.sa, a.sb, a.da, a.fs, a.c0, a.k, a.b_sel, a.flags, a.osz,
                 e.pc, e.sa, e.sb, e.da, e.fs, e.c0, e.k, e.b_sel, e.flags, e.osz);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0000;
    rom[0]  = 32'h910017E1; // ADDI X1, XZR, #5
    rom[1]  = 32'h8B010022; // ADD  X2, X1, X1
    rom[2]  = 32'h8B01003F; // ADD  XZR, X1, X1
    rom[3]  = 32'hCB010044; // SUB  X4, X2, X1
    rom[4]  = 32'hB4FFFFC1; // CBZ  X1, -2
    rom[5]  = 32'h14000003; // B    +3
    rom[8]  = 32'h14000003; // B    +3 (at 0x20)
    rom[11] = 32'hF85F8023; // LDUR X3, [X1, #-8]
    rom[12] = 32'hF8010023; // STUR X3, [X1, #16]
    rom[13] = 32'hB23FFC65; // ORRI X5, X3, #0xFFF
    rom[14] = 32'hD2000486; // EORI X6, X4, #1
    rom[15] = 32'h8A020027; // AND  X7, X1, X2
    rom[16] = 32'hB5000041; // CBNZ X1, +2
    rom[18] = 32'hFFFFFFFF; // illegal
    bus.status = 4'b0000;

    row("reset",       1'b1, 1'b0, idle(64'h0, 1'b0));
    row("fetch0",      1'b0, 1'b0, idle(64'h0, 1'b0));
    row("addi",        1'b0, 1'b0, mk(64'h4, 5'd31, 5'd0, 5'd1, 5'b01000, 1'b0, 64'd5, 1'b1, ALU_W));
    row("fetch4",      1'b0, 1'b0, idle(64'h4, 1'b0));
    row("add",         1'b0, 1'b0, mk(64'h8, 5'd1, 5'd1, 5'd2, 5'b01000, 1'b0, 64'd0, 1'b0, ALU_W));
    row("fetch8",      1'b0, 1'b0, idle(64'h8, 1'b0));
    row("add_xzr",     1'b0, 1'b0, mk(64'hC, 5'd1, 5'd1, 5'd31, 5'b01000, 1'b0, 64'd0, 1'b0, ALU_NW));
    row("fetchC",      1'b0, 1'b0, idle(64'hC, 1'b0));
    row("sub",         1'b0, 1'b0, mk(64'h10, 5'd2, 5'd1, 5'd4, 5'b01001, 1'b1, 64'd0, 1'b0, ALU_W));
    row("fetch10",     1'b0, 1'b0, idle(64'h10, 1'b0));
    row("cbz_taken",   1'b0, 1'b1, mk(64'h14, 5'd1, 5'd0, 5'd0, 5'b00100, 1'b0, 64'd0, 1'b1, NONE));
    row("cbz_tgt",     1'b0, 1'b0, idle(64'h8, 1'b0));
    row("add_xzr2",    1'b0, 1'b0, mk(64'hC, 5'd1, 5'd1, 5'd31, 5'b01000, 1'b0, 64'd0, 1'b0, ALU_NW));
    row("fetchC2",     1'b0, 1'b0, idle(64'hC, 1'b0));
    row("sub2",        1'b0, 1'b0, mk(64'h10, 5'd2, 5'd1, 5'd4, 5'b01001, 1'b1, 64'd0, 1'b0, ALU_W));
    row("fetch10b",    1'b0, 1'b0, idle(64'h10, 1'b0));
    row("cbz_fall",    1'b0, 1'b0, mk(64'h14, 5'd1, 5'd0, 5'd0, 5'b00100, 1'b0, 64'd0, 1'b1, NONE));
    row("cbz_next",    1'b0, 1'b0, idle(64'h14, 1'b0));
    row("b1_exec",     1'b0, 1'b0, idle(64'h18, 1'b0));
    row("b1_tgt",      1'b0, 1'b0, idle(64'h20, 1'b0));
    row("b2_exec",     1'b0, 1'b0, idle(64'h24, 1'b0));
    row("b2_tgt",      1'b0, 1'b0, idle(64'h2C, 1'b0));
    row("ldur_exec",   1'b0, 1'b0, mk(64'h30, 5'd1, 5'd3, 5'd0, 5'b01000, 1'b0, K_M8, 1'b1, LD_EX));
    row("ldur_mem2",   1'b0, 1'b0, mk(64'h30, 5'd1, 5'd3, 5'd3, 5'b01000, 1'b0, K_M8, 1'b1, LD_M2));
    row("fetch30",     1'b0, 1'b0, idle(64'h30, 1'b0));
    row("stur",        1'b0, 1'b0, mk(64'h34, 5'd1, 5'd3, 5'd0, 5'b01000, 1'b0, 64'd16, 1'b1, ST_EX));
    row("fetch34",     1'b0, 1'b0, idle(64'h34, 1'b0));
    row("orri",        1'b0, 1'b0, mk(64'h38, 5'd3, 5'd31, 5'd5, 5'b00100, 1'b0, 64'hFFF, 1'b1, ALU_W));
    row("fetch38",     1'b0, 1'b0, idle(64'h38, 1'b0));
    row("eori",        1'b0, 1'b0, mk(64'h3C, 5'd4, 5'd0, 5'd6, 5'b01100, 1'b0, 64'd1, 1'b1, ALU_W));
    row("fetch3C",     1'b0, 1'b0, idle(64'h3C, 1'b0));
    row("and",         1'b0, 1'b0, mk(64'h40, 5'd1, 5'd2, 5'd7, 5'b00000, 1'b0, 64'd0, 1'b0, ALU_W));
    row("fetch40",     1'b0, 1'b0, idle(64'h40, 1'b0));
    row("cbnz_taken",  1'b0, 1'b0, mk(64'h44, 5'd1, 5'd0, 5'd0, 5'b00100, 1'b0, 64'd0, 1'b1, NONE));
    row("cbnz_tgt",    1'b0, 1'b0, idle(64'h48, 1'b0));
    row("illegal",     1'b0, 1'b0, idle(64'h4C, 1'b0));
    for (int i = 0; i < 3; i++) begin
      row("halt",      1'b0, 1'b1, mk(64'h4C, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b0, HLT));
    end

    rom[0] = 32'hF85F8023; // LDUR at the reset vector for the mid-MEM2 reset case
    row("halt_rst",    1'b1, 1'b0, mk(64'h4C, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b0, HLT));
    row("post_rst",    1'b0, 1'b0, idle(64'h0, 1'b0));
    row("ldur_exec2",  1'b0, 1'b0, mk(64'h4, 5'd1, 5'd3, 5'd0, 5'b01000, 1'b0, K_M8, 1'b1, LD_EX));
    row("mem2_rst",    1'b1, 1'b0, idle(64'h4, 1'b0));
    row("after_rst",   1'b0, 1'b0, idle(64'h0, 1'b0));
    row("ldur_exec3",  1'b0, 1'b0, mk(64'h4, 5'd1, 5'd3, 5'd0, 5'b01000, 1'b0, K_M8, 1'b1, LD_EX));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    if (exp_q.size() > 0) begin
      fails = fails + 1;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
